// File: rtl/tug_pkg.sv
// Package tug_pkg
// Shared types and constants for the tug-of-war match controller:
//   match_state_t  - match sequencing states (PLAY, SCORED, DONE)
//   WIN_*          - encodings for the winner output
//   SEG_DIGIT      - active-low 7-segment patterns {g,f,e,d,c,b,a} for 0..9
//   SEG_BLANK      - all segments off
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    SCORED = 2'd1,
    DONE   = 2'd2
  } match_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/match_controller_seg7_digit.sv
// Module seg7_digit
// Converts a 4-bit binary value to active-low 7-segment drive {g,f,e,d,c,b,a}.
// Values 10..15 have no decimal glyph and are shown blank.
//   value  in  4  binary digit
//   seg    out 7  active-low segments
module seg7_digit
  import tug_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: every signal written in always_comb is assigned a default first,
    // so no path through the block leaves it unassigned and no latch is inferred.
    seg = SEG_BLANK;
    if (value <= 4'd9) seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/match_controller.sv
// Module match_controller
// Sequences a multi-point tug-of-war match. In PLAY it watches the end LEDs
// and the player buttons for a point; after a point the field is frozen and
// recentred for HOLD_CYCLES cycles (SCORED); at WIN_SCORE the match ends
// (DONE) until both players press together to restart.
// All outputs derive from registered state only.
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   L, R        in   player presses (one-cycle pulses, synchronised)
//   LED9, LED1  in   leftmost / rightmost playfield LED lit
//   play_en     out  playfield may move (PLAY only)
//   field_clr   out  playfield returns to centre (SCORED, DONE)
//   score1/2    out  binary scores 0..WIN_SCORE
//   hex_p1/p2   out  scores as active-low 7-segment digits
//   match_over  out  high in DONE
//   winner      out  00 none, 01 player 1, 10 player 2
module match_controller
  import tug_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       LED9,
  input  logic       LED1,
  output logic       play_en,
  output logic       field_clr,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [6:0] hex_p1,
  output logic [6:0] hex_p2,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam int         HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0] WIN_LAST  = 4'(WIN_SCORE - 1);

  generate
    if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win
      $error("match_controller: WIN_SCORE must be in 1..9");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("match_controller: HOLD_CYCLES must be >= 1");
    end
  endgenerate

  match_state_t  state_q, state_d;
  logic [3:0]    score1_d, score2_d;
  logic [1:0]    winner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          p1_pt, p2_pt;

  always_comb begin
    state_d  = state_q;
    score1_d = score1;
    score2_d = score2;
    winner_d = winner;
    hold_d   = hold_q;
    // Simultaneous presses cancel, so the two point conditions never overlap.
    p1_pt    = LED9 & L & ~R;
    p2_pt    = LED1 & R & ~L;

    unique case (state_q)
      PLAY: begin
        if (p1_pt) begin
          score1_d = score1 + 4'd1;
          if (score1 == WIN_LAST) begin
            winner_d = WIN_P1;
            state_d  = DONE;
          end else begin
            hold_d  = HOLD_INIT;
            state_d = SCORED;
          end
        end else if (p2_pt) begin
          score2_d = score2 + 4'd1;
          if (score2 == WIN_LAST) begin
            winner_d = WIN_P2;
            state_d  = DONE;
          end else begin
            hold_d  = HOLD_INIT;
            state_d = SCORED;
          end
        end
      end
      SCORED: begin
        // Entry loads HOLD_CYCLES-1 and exit happens on zero, giving exactly
        // HOLD_CYCLES cycles here.
        if (hold_q == '0) state_d = PLAY;
        else              hold_d  = hold_q - 1'b1;
      end
      DONE: begin
        if (L && R) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = WIN_NONE;
          hold_d   = HOLD_INIT;
          state_d  = SCORED;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q <= PLAY;
      score1  <= '0;
      score2  <= '0;
      winner  <= WIN_NONE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      score1  <= score1_d;
      score2  <= score2_d;
      winner  <= winner_d;
      hold_q  <= hold_d;
    end
  end

  assign play_en    = (state_q == PLAY);
  assign field_clr  = (state_q != PLAY);
  assign match_over = (state_q == DONE);

  seg7_digit u_hex_p1 (.value(score1), .seg(hex_p1));
  seg7_digit u_hex_p2 (.value(score2), .seg(hex_p2));

endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller (WIN_SCORE=7, HOLD_CYCLES=4).
module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       L, R, LED9, LED1;
  logic       play_en, field_clr, match_over;
  logic [3:0] score1, score2;
  logic [6:0] hex_p1, hex_p2;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;

  match_controller #(.WIN_SCORE(7), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .LED9(LED9), .LED1(LED1),
    .play_en(play_en), .field_clr(field_clr), .score1(score1), .score2(score2),
    .hex_p1(hex_p1), .hex_p2(hex_p2), .match_over(match_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    L = 0; R = 0; LED9 = 0; LED1 = 0;
  endtask

  // Counts cycles with field_clr high (current sample included) until PLAY.
  // With noise set, a right-side point attempt is presented in the first one.
  task automatic measure_hold(input string tag, input bit noise, input logic [3:0] s2_exp);
    int n = 0;
    while (field_clr && n < 20) begin
      if (noise && n == 0) begin LED1 = 1; R = 1; end
      tick();
      idle();
      if (noise && n == 0) check({tag, "_s2_frozen"}, score2, s2_exp);
      n++;
    end
    check({tag, "_hold_len"}, n, 4);
    check({tag, "_play_en"}, play_en, 1);
  endtask

  initial begin
    idle();
    // 1. reset
    reset = 0;
    tick(); tick();
    check("rst_score1", score1, 0);
    check("rst_hex_p1", hex_p1, 7'b1000000);
    reset = 1;
    tick();
    check("rel_score2", score2, 0);
    check("rel_hex_p2", hex_p2, 7'b1000000);
    check("rel_play_en", play_en, 1);
    check("rel_field_clr", field_clr, 0);
    check("rel_winner", winner, 2'b00);
    check("rel_match_over", match_over, 0);

    // 2. player 1 point
    LED9 = 1; L = 1;
    tick();
    idle();
    check("p1_score1", score1, 1);
    check("p1_hex_p1", hex_p1, 7'b1111001);
    check("p1_field_clr", field_clr, 1);
    check("p1_play_en", play_en, 0);
    measure_hold("p1", 0, 0);

    // 3. simultaneous presses at both ends
    LED9 = 1; LED1 = 1; L = 1; R = 1;
    tick();
    idle();
    check("lr_score1", score1, 1);
    check("lr_score2", score2, 0);
    check("lr_play_en", play_en, 1);

    // 2b / 4. right press during SCORED is ignored; hold still 4 cycles
    LED9 = 1; L = 1;
    tick();
    idle();
    check("p1b_score1", score1, 2);
    check("p1b_hex_p1", hex_p1, 7'b0100100);
    measure_hold("noise", 1, 0);

    // 5. player 2 wins with 7 points
    for (int i = 1; i <= 7; i++) begin
      LED1 = 1; R = 1;
      tick();
      idle();
      check($sformatf("p2_pt%0d", i), score2, i);
      if (i < 7) measure_hold($sformatf("p2_h%0d", i), 0, 4'(i));
    end
    check("done_match_over", match_over, 1);
    check("done_winner", winner, 2'b10);
    check("done_hex_p2", hex_p2, 7'b1111000);
    check("done_field_clr", field_clr, 1);
    check("done_play_en", play_en, 0);

    LED9 = 1; L = 1;
    tick();
    idle();
    check("done_ign_score1", score1, 2);
    check("done_ign_winner", winner, 2'b10);
    check("done_ign_over", match_over, 1);

    L = 1; R = 1;
    tick();
    idle();
    check("restart_score1", score1, 0);
    check("restart_score2", score2, 0);
    check("restart_winner", winner, 2'b00);
    check("restart_over", match_over, 0);
    check("restart_hex_p2", hex_p2, 7'b1000000);
    measure_hold("restart", 0, 0);

    // 6. async reset in mid-SCORED
    LED1 = 1; R = 1;
    tick();
    idle();
    check("pre_rst_score2", score2, 1);
    tick();
    check("pre_rst_field_clr", field_clr, 1);
    #2 reset = 0;
    #1;
    check("async_play_en", play_en, 1);
    check("async_field_clr", field_clr, 0);
    check("async_score2", score2, 0);
    check("async_hex_p2", hex_p2, 7'b1000000);
    check("async_winner", winner, 2'b00);
    @(negedge clk);
    reset = 1;
    tick();
    check("post_rst_play_en", play_en, 1);
    LED9 = 1; L = 1;
    tick();
    idle();
    check("post_rst_score1", score1, 1);
    measure_hold("post_rst", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
